spi_minion_multichan_adapter: RTL and testbench

SPI minion with a built-in multi-channel adapter. It terminates an SPI link from an off-chip master and routes each frame to one of `nchan` independent val/rdy channel pairs using an address field carried in the frame. Each channel has its own FIFO in each direction. This is the multi-channel, addressed successor to the single-channel minion/adapter composite, and it sits between the chip's SPI pins and on-chip accelerators or host-interface logic.

---
 rtl/spi_minion_mc_pkg.sv | 27 ++
 rtl/spi_minion_mc_fifo.sv | 58 +++++
 rtl/spi_minion_multichan_adapter.sv | 188 ++++++++++++++++++
 tb/tb_spi_minion_multichan_adapter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_minion_mc_pkg.sv
// Shared definitions for the multi-channel SPI minion adapter.
//   state_e    : minion FSM states
//   calc_abits : channel-address width for a given channel count
//   FLD_*      : frame field positions, counted down from the frame MSB
package spi_minion_mc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Smallest r with 2**r >= n.
  function automatic int calc_abits(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Field bit index = nbits - FLD_x (val_wrt/val on top, then val_rd/spc,
  // then the address MSB).
  localparam int FLD_VAL_WRT = 1;
  localparam int FLD_VAL_RD  = 2;
  localparam int FLD_ADDR    = 3;

endpackage

// File: rtl/spi_minion_mc_fifo.sv
// Registered synchronous FIFO with val/rdy on both sides, no bypass.
//   enq_val/enq_msg : write side; accepted when not full, or when full
//                     and a dequeue happens in the same cycle
//   full            : occupancy == num_entries
//   deq_val/deq_rdy/deq_msg : read side, deq_msg is the head entry
module spi_minion_mc_fifo #(
  parameter int dbits       = 4,
  parameter int num_entries = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  input  logic [dbits-1:0] enq_msg,
  output logic             full,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [dbits-1:0] deq_msg
);

  localparam int PW = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam int CW = $clog2(num_entries + 1);

  logic [num_entries-1:0][dbits-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          enq_fire, deq_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(num_entries - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(num_entries));
  assign deq_val  = (count != '0);
  assign deq_msg  = mem[rd_ptr];
  assign deq_fire = deq_val & deq_rdy;
  assign enq_fire = enq_val & (~full | deq_fire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) begin
        mem[wr_ptr] <= enq_msg;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (deq_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_minion_multichan_adapter.sv
// SPI (mode 0) minion that routes each frame to one of nchan val/rdy
// channel pairs selected by an address field in the frame.
//   clk, reset (async, active low)
//   cs, sclk, mosi, miso        : SPI pins (cs active low)
//   recv_msg/val/rdy            : per-channel data into the read FIFOs
//   send_msg/val/rdy            : per-channel data out of the write FIFOs
//   wr_drop                     : pulse when a write hits a full/absent FIFO
//   minion_parity               : XOR of data of the last accepted frame
//   adapter_parity              : XOR of data of the last loaded outbound frame
module spi_minion_multichan_adapter
  import spi_minion_mc_pkg::*;
#(
  parameter int  nbits       = 8,
  parameter int  nchan       = 4,
  parameter int  num_entries = 2,
  localparam int abits       = calc_abits(nchan),
  localparam int dbits       = nbits - 2 - abits
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs,
  input  logic                   sclk,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [nchan*dbits-1:0] recv_msg,
  input  logic [nchan-1:0]       recv_val,
  output logic [nchan-1:0]       recv_rdy,
  output logic [nchan*dbits-1:0] send_msg,
  output logic [nchan-1:0]       send_val,
  input  logic [nchan-1:0]       send_rdy,
  output logic                   wr_drop,
  output logic                   minion_parity,
  output logic                   adapter_parity
);

  localparam int NSEL = 1 << abits;           // address space incl. unused codes
  localparam int CW   = $clog2(nbits + 2);

  // ---------------- pin synchronisers + edge detect ----------------
  logic cs_s1, cs_s2, cs_q, sclk_s1, sclk_s2, sclk_q, mosi_s1, mosi_s2;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {cs_s1, cs_s2, cs_q}       <= 3'b111;
      {sclk_s1, sclk_s2, sclk_q} <= 3'b111;
      {mosi_s1, mosi_s2}         <= 2'b00;
    end else begin
      {cs_s1, cs_s2, cs_q}       <= {cs, cs_s1, cs_s2};
      {sclk_s1, sclk_s2, sclk_q} <= {sclk, sclk_s1, sclk_s2};
      {mosi_s1, mosi_s2}         <= {mosi, mosi_s1};
    end
  end

  assign cs_fall   =  cs_q   & ~cs_s2;
  assign cs_rise   = ~cs_q   &  cs_s2;
  assign sclk_rise = ~sclk_q &  sclk_s2;
  assign sclk_fall =  sclk_q & ~sclk_s2;

  // ---------------- FSM ----------------
  state_e          state, state_nxt;
  logic            do_pull, do_push;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A frame is only acted on if exactly nbits bits were clocked in.
  always_comb begin
    do_pull = 1'b0;
    do_push = 1'b0;
    case (state)
      IDLE:    do_pull = cs_fall;
      SHIFT:   do_push = cs_rise & (cnt == CW'(nbits));
      default: ;
    endcase
  end

  // ---------------- frame fields ----------------
  logic [nbits-1:0] shreg;
  logic             in_val_wrt, in_val_rd;
  logic [abits-1:0] in_addr;
  logic [dbits-1:0] in_data;

  assign in_val_wrt = shreg[nbits-FLD_VAL_WRT];
  assign in_val_rd  = shreg[nbits-FLD_VAL_RD];
  assign in_addr    = shreg[nbits-FLD_ADDR -: abits];
  assign in_data    = shreg[dbits-1:0];

  // ---------------- channel FIFOs ----------------
  // Arrays span the whole address space; unused codes look like a full,
  // empty channel so out-of-range writes drop and reads return val=0.
  logic [NSEL-1:0]            rf_val_x, wf_full_x, rf_deq;
  logic [NSEL-1:0][dbits-1:0] rf_msg_x;
  logic                       rd_pend, pull_hit;
  logic [abits-1:0]           rd_sel;

  for (genvar j = 0; j < NSEL; j++) begin : g_sel
    if (j < nchan) begin : g_ch
      logic rf_full;

      assign rf_deq[j]   = do_pull & pull_hit & (rd_sel == abits'(j));
      assign recv_rdy[j] = ~rf_full;

      spi_minion_mc_fifo #(.dbits(dbits), .num_entries(num_entries)) u_rd_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq_val (recv_val[j] & ~rf_full),
        .enq_msg (recv_msg[j*dbits +: dbits]),
        .full    (rf_full),
        .deq_val (rf_val_x[j]),
        .deq_rdy (rf_deq[j]),
        .deq_msg (rf_msg_x[j])
      );

      spi_minion_mc_fifo #(.dbits(dbits), .num_entries(num_entries)) u_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq_val (do_push & in_val_wrt & (in_addr == abits'(j)) & ~wf_full_x[j]),
        .enq_msg (in_data),
        .full    (wf_full_x[j]),
        .deq_val (send_val[j]),
        .deq_rdy (send_rdy[j]),
        .deq_msg (send_msg[j*dbits +: dbits])
      );
    end else begin : g_pad
      assign rf_deq[j]    = 1'b0;
      assign rf_val_x[j]  = 1'b0;
      assign rf_msg_x[j]  = '0;
      assign wf_full_x[j] = 1'b1;
    end
  end

  // ---------------- outbound frame ----------------
  logic [nbits-1:0] pull_frame;

  assign pull_hit   = rd_pend & rf_val_x[rd_sel];
  assign pull_frame = {pull_hit, ~wf_full_x[rd_sel], rd_sel,
                       pull_hit ? rf_msg_x[rd_sel] : {dbits{1'b0}}};

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg          <= '0;
      cnt            <= '0;
      miso           <= 1'b0;
      rd_pend        <= 1'b0;
      rd_sel         <= '0;
      wr_drop        <= 1'b0;
      minion_parity  <= 1'b0;
      adapter_parity <= 1'b0;
    end else begin
      wr_drop <= do_push & in_val_wrt & wf_full_x[in_addr];
      if (do_pull) begin
        shreg          <= pull_frame;
        cnt            <= '0;
        miso           <= pull_frame[nbits-1];
        rd_pend        <= 1'b0;
        adapter_parity <= ^pull_frame[dbits-1:0];
      end else if (state == SHIFT) begin
        if (sclk_rise) begin
          shreg <= {shreg[nbits-2:0], mosi_s2};
          if (cnt != CW'(nbits + 1)) cnt <= cnt + CW'(1);
        end
        if (sclk_fall) miso <= shreg[nbits-1];
      end
      if (do_push) begin
        minion_parity <= ^in_data;
        if (in_val_rd) begin
          rd_pend <= 1'b1;
          rd_sel  <= in_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_minion_multichan_adapter.sv
// Directed bench for spi_minion_multichan_adapter (nbits=8, nchan=4,
// num_entries=2). Expected send-channel traffic goes into a scoreboard
// queue; a negedge monitor pops and compares on every send handshake.
module tb_spi_minion_multichan_adapter;

  logic        clk = 1'b0, reset = 1'b0, cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic        miso, wr_drop, minion_parity, adapter_parity;
  logic [15:0] recv_msg = '0, send_msg;
  logic [3:0]  recv_val = '0, recv_rdy, send_val, send_rdy = '0;

  always #5 clk = ~clk;

  spi_minion_multichan_adapter #(.nbits(8), .nchan(4), .num_entries(2)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .wr_drop(wr_drop), .minion_parity(minion_parity), .adapter_parity(adapter_parity)
  );

  typedef struct { int chan; logic [3:0] data; } send_t;
  send_t exp_send[$];
  int n_cmp = 0, n_err = 0, drop_cnt = 0, drop0;
  logic [7:0] rx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation on every send handshake.
  always @(negedge clk) begin
    send_t e;
    if (wr_drop) drop_cnt++;
    for (int i = 0; i < 4; i++)
      if (send_val[i] && send_rdy[i]) begin
        if (exp_send.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL send_unexpected: chan %0d data %0h expected none", i, send_msg[i*4 +: 4]);
        end else begin
          e = exp_send.pop_front();
          chk("send_chan", i, e.chan);
          chk("send_data", send_msg[i*4 +: 4], e.data);
        end
      end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic spi_frame(input logic [7:0] tx, input int nb, input bit raise_cs,
                           output logic [7:0] r);
    r = '0;
    cs = 1'b0;
    cyc(6);
    for (int k = 0; k < nb; k++) begin
      mosi = tx[7-k];
      cyc(6);
      r[7-k] = miso;
      sclk = 1'b1;
      cyc(6);
      sclk = 1'b0;
    end
    if (raise_cs) begin
      cyc(6);
      cs = 1'b1;
      mosi = 1'b0;
      cyc(8);
    end
  endtask

  task automatic frame(input logic [7:0] tx, input logic [7:0] exp_rx, input string name);
    logic [7:0] r;
    spi_frame(tx, 8, 1'b1, r);
    chk(name, r, exp_rx);
  endtask

  task automatic recv(input int ch, input logic [3:0] d);
    recv_msg[ch*4 +: 4] = d;
    recv_val[ch] = 1'b1;
    cyc(1);
    recv_val[ch] = 1'b0;
  endtask

  task automatic drain(input int ch, input int n);
    send_rdy[ch] = 1'b1;
    cyc(n);
    send_rdy[ch] = 1'b0;
    cyc(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_recv_rdy"}, recv_rdy, 4'hF);
    chk({tag, "_send_val"}, send_val, 4'h0);
    chk({tag, "_send_msg"}, send_msg, 16'h0);
    chk({tag, "_miso"}, miso, 1'b0);
    chk({tag, "_wr_drop"}, wr_drop, 1'b0);
    chk({tag, "_mpar"}, minion_parity, 1'b0);
    chk({tag, "_apar"}, adapter_parity, 1'b0);
  endtask

  initial begin
    cyc(3);
    chk_reset_vals("rst");
    reset = 1'b1;
    cyc(3);

    // Write 0xA5 -> channel 2, data 5
    exp_send.push_back('{2, 4'h5});
    frame(8'hA5, 8'h40, "wr_rx");
    chk("wr_send_val", send_val, 4'b0100);
    chk("wr_send_msg", send_msg, 16'h0500);
    chk("wr_mpar", minion_parity, 1'b0);
    drain(2, 1);
    chk("wr_drained", send_val, 4'h0);

    // Read channel 1 holding 0xC
    recv(1, 4'hC);
    cyc(1);
    frame(8'h50, 8'h40, "rd_cmd_rx");
    frame(8'h00, 8'hDC, "rd_data_rx");
    chk("rd_recv_rdy", recv_rdy, 4'hF);
    chk("rd_apar", adapter_parity, 1'b0);

    // Read from empty channel 3
    frame(8'h70, 8'h50, "empty_cmd_rx");
    frame(8'h00, 8'h70, "empty_data_rx");
    chk("empty_apar", adapter_parity, 1'b0);

    // Read channel 3 holding 0x7 (odd parity)
    recv(3, 4'h7);
    cyc(1);
    frame(8'h70, 8'h70, "odd_cmd_rx");
    frame(8'h00, 8'hF7, "odd_data_rx");
    chk("odd_apar", adapter_parity, 1'b1);

    // Fill write FIFO 0, third write drops
    exp_send.push_back('{0, 4'h1});
    exp_send.push_back('{0, 4'h2});
    drop0 = drop_cnt;
    frame(8'h81, 8'h70, "full1_rx");
    chk("full1_send_val", send_val, 4'b0001);
    chk("full1_mpar", minion_parity, 1'b1);
    frame(8'h82, 8'h70, "full2_rx");
    chk("full2_mpar", minion_parity, 1'b1);
    chk("full2_nodrop", drop_cnt - drop0, 0);
    frame(8'h83, 8'h70, "full3_rx");
    chk("full3_drop", drop_cnt - drop0, 1);
    chk("full3_mpar", minion_parity, 1'b0);
    chk("full3_head", send_msg[3:0], 4'h1);
    frame(8'h40, 8'h70, "full_rdcmd_rx");
    frame(8'h00, 8'h00, "full_spc_rx");
    drain(0, 2);
    chk("full_drained", send_val, 4'h0);

    // Short frame: 5 bits, must be discarded
    frame(8'h01, 8'h40, "pre_short_rx");
    chk("pre_short_mpar", minion_parity, 1'b1);
    spi_frame(8'hFF, 5, 1'b1, rx);
    chk("short_mpar", minion_parity, 1'b1);
    chk("short_send_val", send_val, 4'h0);
    frame(8'h00, 8'h40, "short_rdpend_rx");

    // Reset in the middle of a frame
    frame(8'hA5, 8'h40, "prerst_wr_rx");
    chk("prerst_send_val", send_val, 4'b0100);
    frame(8'h07, 8'h40, "prerst_par_rx");
    chk("prerst_mpar", minion_parity, 1'b1);
    recv(0, 4'h3);
    recv(0, 4'h4);
    cyc(1);
    chk("prerst_recv_rdy", recv_rdy, 4'b1110);
    drop0 = drop_cnt;
    spi_frame(8'h81, 4, 1'b0, rx);
    reset = 1'b0;
    cyc(2);
    chk_reset_vals("midrst");
    cyc(2);
    reset = 1'b1;
    cyc(10);
    cs = 1'b1;
    cyc(8);
    chk("postrst_send_val", send_val, 4'h0);
    chk("postrst_mpar", minion_parity, 1'b0);
    chk("postrst_nodrop", drop_cnt - drop0, 0);
    exp_send.push_back('{2, 4'h5});
    frame(8'hA5, 8'h40, "postrst_wr_rx");
    chk("postrst_wr_val", send_val, 4'b0100);
    chk("postrst_wr_msg", send_msg, 16'h0500);
    drain(2, 1);

    chk("sb_empty", exp_send.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
